exec_wr_scoreboard: RTL and testbench

//  Synthesizable scoreboard for the PDP-8 EXEC memory-write port; successor to the sim-only exec checker.

---
 rtl/exec_wr_scoreboard.sv | 169 ++++++++++++++++
 tb/tb_exec_wr_scoreboard.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_wr_scoreboard.sv
// In-order scoreboard for the PDP-8 EXEC memory-write port, with a read-request
// watchdog, saturating error counter and first-error address capture.
module exec_wr_scoreboard #(
  parameter int DATA_WIDTH    = 12,
  parameter int ADDR_WIDTH    = 12,
  parameter int DEPTH         = 4,
  parameter int RD_TIMEOUT    = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       chk_enable,
  input  logic                       clear_errors,
  input  logic                       exp_valid,
  input  logic [ADDR_WIDTH-1:0]      exp_addr,
  input  logic [DATA_WIDTH-1:0]      exp_data,
  output logic                       exp_ready,
  input  logic                       exec_wr_req,
  input  logic [ADDR_WIDTH-1:0]      exec_wr_addr,
  input  logic [DATA_WIDTH-1:0]      exec_wr_data,
  input  logic                       exec_rd_req,
  output logic                       mismatch,
  output logic                       unexpected_wr,
  output logic                       rd_stuck,
  output logic                       overflow,
  output logic                       sticky_err,
  output logic [ERR_CNT_WIDTH-1:0]   err_count,
  output logic [ADDR_WIDTH-1:0]      first_err_addr,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PCNT_W = PTR_W + 1;
  localparam int CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {RD_IDLE, RD_ACTIVE, RD_STUCK} rd_state_t;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;

  logic empty, full, pop, push, ovf_evt, mis_evt, unexp_evt, wr_err_evt, rd_evt;
  logic wr_err_seen;
  rd_state_t rd_state, rd_state_next;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_next;
  logic [1:0] err_inc;
  logic [ERR_CNT_WIDTH:0] err_sum;

  assign empty = (pending == '0);
  assign full  = (pending == PCNT_W'(DEPTH));
  assign pop   = chk_enable & exec_wr_req & ~empty;
  assign push  = chk_enable & exp_valid & (~full | pop);
  assign exp_ready = chk_enable & (~full | pop);

  // The head is compared before any same-cycle push lands in the queue.
  assign ovf_evt    = chk_enable & exp_valid & full & ~pop;
  assign mis_evt    = pop & ((exec_wr_addr != addr_mem[rd_ptr]) | (exec_wr_data != data_mem[rd_ptr]));
  assign unexp_evt  = chk_enable & exec_wr_req & empty;
  assign wr_err_evt = mis_evt | unexp_evt;

  assign err_inc = {1'b0, wr_err_evt} + {1'b0, rd_evt} + {1'b0, ovf_evt};
  assign err_sum = {1'b0, err_count} + (ERR_CNT_WIDTH + 1)'(err_inc);

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= exp_addr;
      data_mem[wr_ptr] <= exp_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else if (!chk_enable) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      pending <= pending + PCNT_W'(1);
      else if (pop && !push) pending <= pending - PCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= RD_IDLE;
      rd_cnt   <= '0;
    end else begin
      rd_state <= rd_state_next;
      rd_cnt   <= rd_cnt_next;
    end
  end

  always_comb begin
    rd_state_next = rd_state;
    rd_cnt_next   = rd_cnt;
    if (!chk_enable) begin
      rd_state_next = RD_IDLE;
      rd_cnt_next   = '0;
    end else begin
      case (rd_state)
        RD_IDLE: if (exec_rd_req) begin
          rd_state_next = RD_ACTIVE;
          rd_cnt_next   = CNT_W'(1);
        end
        RD_ACTIVE: begin
          if (!exec_rd_req) begin
            rd_state_next = RD_IDLE;
            rd_cnt_next   = '0;
          end else if (rd_cnt == CNT_W'(RD_TIMEOUT)) begin
            rd_state_next = RD_STUCK;
          end else begin
            rd_cnt_next = rd_cnt + CNT_W'(1);
          end
        end
        RD_STUCK: if (!exec_rd_req) begin
          rd_state_next = RD_IDLE;
          rd_cnt_next   = '0;
        end
        default: begin
          rd_state_next = RD_IDLE;
          rd_cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    rd_evt = chk_enable & exec_rd_req & (rd_state == RD_ACTIVE) & (rd_cnt == CNT_W'(RD_TIMEOUT));
  end

  // Pulses are never masked by clear_errors; only the accumulated state is.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mismatch       <= 1'b0;
      unexpected_wr  <= 1'b0;
      rd_stuck       <= 1'b0;
      overflow       <= 1'b0;
      sticky_err     <= 1'b0;
      wr_err_seen    <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      mismatch      <= mis_evt;
      unexpected_wr <= unexp_evt;
      rd_stuck      <= rd_evt;
      if (clear_errors) begin
        overflow       <= 1'b0;
        sticky_err     <= 1'b0;
        wr_err_seen    <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
      end else begin
        if (ovf_evt) overflow <= 1'b1;
        if (wr_err_evt | rd_evt | ovf_evt) sticky_err <= 1'b1;
        if (wr_err_evt && !wr_err_seen) begin
          wr_err_seen    <= 1'b1;
          first_err_addr <= exec_wr_addr;
        end
        err_count <= err_sum[ERR_CNT_WIDTH] ? '1 : err_sum[ERR_CNT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_exec_wr_scoreboard.sv
// Directed self-checking bench for exec_wr_scoreboard with the default parameters
// (12-bit addr/data, DEPTH=4, RD_TIMEOUT=1, 8-bit error counter).
module tb_exec_wr_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chk_enable, clear_errors, exp_valid, exec_wr_req, exec_rd_req;
  logic [11:0] exp_addr, exp_data, exec_wr_addr, exec_wr_data;
  logic        exp_ready, mismatch, unexpected_wr, rd_stuck, overflow, sticky_err;
  logic [7:0]  err_count;
  logic [11:0] first_err_addr;
  logic [2:0]  pending;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  exec_wr_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .chk_enable(chk_enable), .clear_errors(clear_errors),
    .exp_valid(exp_valid), .exp_addr(exp_addr), .exp_data(exp_data), .exp_ready(exp_ready),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
    .exec_rd_req(exec_rd_req), .mismatch(mismatch), .unexpected_wr(unexpected_wr),
    .rd_stuck(rd_stuck), .overflow(overflow), .sticky_err(sticky_err),
    .err_count(err_count), .first_err_addr(first_err_addr), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_errors = 0; exp_valid = 0; exec_wr_req = 0; exec_rd_req = 0;
    exp_addr = 0; exp_data = 0; exec_wr_addr = 0; exec_wr_data = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; chk_enable = 1; idle_inputs();
    #12 reset_n = 1;
    step();
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending); end
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    n_cmp++; if ({mismatch, unexpected_wr, rd_stuck, overflow, sticky_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {mismatch, unexpected_wr, rd_stuck, overflow, sticky_err}); end
    n_cmp++; if (first_err_addr !== 12'h000) begin n_fail++; $display("FAIL reset_first_err: got %h want 000", first_err_addr); end
    n_cmp++; if (exp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_exp_ready: got %b want 1", exp_ready); end
  endtask

  task automatic test_match();
    exp_valid = 1; exp_addr = 12'h010; exp_data = 12'h7FF;
    step();
    exp_valid = 0;
    n_cmp++; if (pending !== 3'd1) begin n_fail++; $display("FAIL match_push_pending: got %0d want 1", pending); end
    exec_wr_req = 1; exec_wr_addr = 12'h010; exec_wr_data = 12'h7FF;
    step();
    exec_wr_req = 0;
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL match_pop_pending: got %0d want 0", pending); end
    n_cmp++; if ({mismatch, unexpected_wr} !== 2'b00) begin n_fail++; $display("FAIL match_pulses: got %b want 00", {mismatch, unexpected_wr}); end
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL match_err_count: got %0d want 0", err_count); end
  endtask

  task automatic test_mismatch();
    exp_valid = 1; exp_addr = 12'h020; exp_data = 12'h001;
    step();
    exp_valid = 0;
    exec_wr_req = 1; exec_wr_addr = 12'h020; exec_wr_data = 12'h002;
    step();
    exec_wr_req = 0;
    n_cmp++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL mismatch_pulse: got %b want 1", mismatch); end
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL mismatch_err_count: got %0d want 1", err_count); end
    n_cmp++; if (first_err_addr !== 12'h020) begin n_fail++; $display("FAIL mismatch_first_err: got %h want 020", first_err_addr); end
    n_cmp++; if (sticky_err !== 1'b1) begin n_fail++; $display("FAIL mismatch_sticky: got %b want 1", sticky_err); end
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL mismatch_popped: got %0d want 0", pending); end
    step();
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL mismatch_one_cycle: got %b want 0", mismatch); end
  endtask

  task automatic test_unexpected();
    exec_wr_req = 1; exec_wr_addr = 12'h030; exec_wr_data = 12'h055;
    exp_valid = 1; exp_addr = 12'h040; exp_data = 12'h123;
    step();
    exec_wr_req = 0; exp_valid = 0;
    n_cmp++; if (unexpected_wr !== 1'b1) begin n_fail++; $display("FAIL unexp_pulse: got %b want 1", unexpected_wr); end
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL unexp_no_mismatch: got %b want 0", mismatch); end
    n_cmp++; if (pending !== 3'd1) begin n_fail++; $display("FAIL unexp_pending: got %0d want 1", pending); end
    n_cmp++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL unexp_err_count: got %0d want 2", err_count); end
    n_cmp++; if (first_err_addr !== 12'h020) begin n_fail++; $display("FAIL unexp_first_err_kept: got %h want 020", first_err_addr); end
    exec_wr_req = 1; exec_wr_addr = 12'h040; exec_wr_data = 12'h123;
    step();
    exec_wr_req = 0;
    n_cmp++; if ({mismatch, unexpected_wr, pending} !== 5'b0) begin
      n_fail++; $display("FAIL unexp_drain: got %b want 00000", {mismatch, unexpected_wr, pending}); end
  endtask

  task automatic test_overflow();
    clear_errors = 1; step(); clear_errors = 0;
    for (int i = 0; i < 4; i++) begin
      exp_valid = 1; exp_addr = 12'h100 + 12'(i); exp_data = 12'h200 + 12'(i);
      step();
    end
    exp_valid = 0; #1;
    n_cmp++; if (pending !== 3'd4) begin n_fail++; $display("FAIL ovf_fill_pending: got %0d want 4", pending); end
    n_cmp++; if (exp_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_full_ready: got %b want 0", exp_ready); end
    exp_valid = 1; exp_addr = 12'h1EE; exp_data = 12'h2EE;
    step();
    exp_valid = 0;
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (pending !== 3'd4) begin n_fail++; $display("FAIL ovf_drop_pending: got %0d want 4", pending); end
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL ovf_err_count: got %0d want 1", err_count); end
    exp_valid = 1; exp_addr = 12'h104; exp_data = 12'h204;
    exec_wr_req = 1; exec_wr_addr = 12'h100; exec_wr_data = 12'h200;
    #1;
    n_cmp++; if (exp_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_on_pop: got %b want 1", exp_ready); end
    step();
    exp_valid = 0;
    n_cmp++; if (pending !== 3'd4) begin n_fail++; $display("FAIL ovf_pushpop_pending: got %0d want 4", pending); end
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL ovf_pushpop_no_err: got %0d want 1", err_count); end
    for (int i = 1; i <= 4; i++) begin
      exec_wr_req = 1; exec_wr_addr = 12'h100 + 12'(i); exec_wr_data = 12'h200 + 12'(i);
      step();
      n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL ovf_drain_%0d: mismatch got %b want 0", i, mismatch); end
    end
    exec_wr_req = 0;
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL ovf_drain_pending: got %0d want 0", pending); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_watchdog();
    int pulses;
    clear_errors = 1; step(); clear_errors = 0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      exec_rd_req = (i < 3);
      step();
      if (rd_stuck === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL wd_long_req: pulses got %0d want 1", pulses); end
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL wd_err_count: got %0d want 1", err_count); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      exec_rd_req = (i == 0);
      step();
      if (rd_stuck === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL wd_short_req: pulses got %0d want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    clear_errors = 1; step(); clear_errors = 0;
    exp_valid = 1; exp_addr = 12'h000; exp_data = 12'h000;
    step();
    exec_wr_req = 1; exec_wr_addr = 12'h055; exec_wr_data = 12'h001;
    for (int i = 0; i < 300; i++) step();
    exec_wr_req = 0; exp_valid = 0;
    n_cmp++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL sat_err_count: got %h want ff", err_count); end
    n_cmp++; if (pending !== 3'd1) begin n_fail++; $display("FAIL sat_pending: got %0d want 1", pending); end
    n_cmp++; if (first_err_addr !== 12'h055) begin n_fail++; $display("FAIL sat_first_err: got %h want 055", first_err_addr); end
    clear_errors = 1; step(); clear_errors = 0;
    n_cmp++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL clear_err_count: got %h want 00", err_count); end
    n_cmp++; if ({sticky_err, first_err_addr} !== 13'h0) begin
      n_fail++; $display("FAIL clear_sticky: got %b/%h want 0/000", sticky_err, first_err_addr); end
    n_cmp++; if (pending !== 3'd1) begin n_fail++; $display("FAIL clear_keeps_queue: got %0d want 1", pending); end
  endtask

  task automatic test_chk_disable();
    exp_valid = 1; exp_addr = 12'h0AA; exp_data = 12'h0BB;
    step();
    exp_valid = 0;
    chk_enable = 0; exec_wr_req = 1; exec_wr_addr = 12'h777; #1;
    n_cmp++; if (exp_ready !== 1'b0) begin n_fail++; $display("FAIL dis_ready: got %b want 0", exp_ready); end
    step();
    exec_wr_req = 0;
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL dis_flush: got %0d want 0", pending); end
    n_cmp++; if ({mismatch, unexpected_wr, err_count} !== 10'h0) begin
      n_fail++; $display("FAIL dis_no_pulse: got %b/%b/%0d want 0/0/0", mismatch, unexpected_wr, err_count); end
    chk_enable = 1;
  endtask

  task automatic test_reset_mid();
    exp_valid = 1; exp_addr = 12'h3C3; exp_data = 12'h3C3;
    step(); step();
    exp_valid = 0;
    clear_errors = 0; exec_wr_req = 1; exec_wr_addr = 12'h111; step(); exec_wr_req = 0;
    reset_n = 0; #1;
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL rst_mid_pending: got %0d want 0", pending); end
    n_cmp++; if ({mismatch, sticky_err, err_count} !== 10'h0) begin
      n_fail++; $display("FAIL rst_mid_flags: got %b/%b/%0d want 0/0/0", mismatch, sticky_err, err_count); end
    step();
    reset_n = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_unexpected();
    test_overflow();
    test_watchdog();
    test_back_to_back();
    test_chk_disable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
